// File: rtl/mux_nto1_reg_hs.sv
// NUM_IN:1 valid/ready mux into a single registered output stage, fixed-select or round-robin.
// Optional OUT_PAR parity output is enabled by defining MUX_NTO1_PARITY_EN.
module mux_nto1_reg_hs #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
`ifdef MUX_NTO1_PARITY_EN
    ,
    output logic                    out_par
`endif
);

    generate
        if (WIDTH < 1 || NUM_IN < 2 || NUM_IN > 16 || (2 ** SEL_W) < NUM_IN) begin : g_param_check
            $error("mux_nto1_reg_hs: invalid WIDTH/NUM_IN/SEL_W combination");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);
    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic [SEL_W-1:0]    ptr;
    logic [SEL_W-1:0]    gnt;
    logic                gnt_ok;
    logic [WIDTH-1:0]    gnt_data;
    logic                load_en;
    logic [2*NUM_IN-1:0] rot_valid;
    logic [SEL_W:0]      rr_idx;

    assign load_en   = !out_valid || out_ready;
    // Bit k of the rotated vector is the valid of channel (ptr+k) mod NUM_IN.
    assign rot_valid = {in_valid, in_valid} >> ptr;

    // NOTE: every combinational output gets a default before the branches, so no latch is inferred.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        rr_idx = '0;
        if (!mode) begin
            gnt = sel;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) gnt_ok = 1'b1;
            end
        end else begin
            // Walk from farthest to nearest so the channel closest to ptr wins.
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (rot_valid[k]) begin
                    rr_idx = {1'b0, ptr} + (SEL_W + 1)'(k);
                    if (rr_idx >= NUM_IN_W) rr_idx = rr_idx - NUM_IN_W;
                    gnt    = rr_idx[SEL_W-1:0];
                    gnt_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (gnt == SEL_W'(j)) gnt_data = in_bus[j*WIDTH +: WIDTH];
        end
    end

    // Ready is held low while in reset so no producer sees a handshake that cannot complete.
    always_comb begin
        in_ready = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            in_ready[j] = rst_n && load_en && gnt_ok && (gnt == SEL_W'(j));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef MUX_NTO1_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (load_en && gnt_ok) begin
            out       <= gnt_data;
            out_ch    <= gnt;
            out_valid <= 1'b1;
`ifdef MUX_NTO1_PARITY_EN
            out_par   <= ^gnt_data;
`endif
            if (mode) ptr <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg_hs.sv
// Self-checking bench for mux_nto1_reg_hs: scoreboard of expected words plus per-scenario checks.
// A second 3-channel instance covers the out-of-range select case.
module tb_mux_nto1_reg_hs;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        logic       par;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_bus;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [23:0] in_bus3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [7:0]  out3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;
`ifdef MUX_NTO1_PARITY_EN
    logic        out_par;
    logic        out_par3;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    bit   m_ov;
    int   m_ptr;

    mux_nto1_reg_hs #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
`ifdef MUX_NTO1_PARITY_EN
        , .out_par(out_par)
`endif
    );

    mux_nto1_reg_hs #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out(out3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
`ifdef MUX_NTO1_PARITY_EN
        , .out_par(out_par3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_grant(output int g, output bit ok);
        g  = 0;
        ok = 1'b0;
        if (!mode) begin
            g  = int'(sel);
            ok = in_valid[g];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!ok && in_valid[(m_ptr + k) % 4]) begin
                    g  = (m_ptr + k) % 4;
                    ok = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_ov  = 1'b0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs already driven, check against the model, then advance.
    task automatic step();
        int         g;
        bit         ok;
        bit         load_en;
        logic [3:0] exp_rdy;
        exp_t       e;
        #1;
        load_en = !m_ov || out_ready;
        model_grant(g, ok);
        exp_rdy = (load_en && ok) ? 4'(1 << g) : 4'b0000;
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        checks++;
        if (out_valid !== m_ov) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
        end
        if (m_ov) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard: output valid with no expected word");
            end else begin
                e = exp_q[0];
                if (out !== e.data || out_ch !== e.ch) begin
                    failures++;
                    $display("FAIL out_word: got data=%0h ch=%0d expected data=%0h ch=%0d",
                             out, out_ch, e.data, e.ch);
                end
`ifdef MUX_NTO1_PARITY_EN
                checks++;
                if (out_par !== e.par) begin
                    failures++;
                    $display("FAIL out_par: got %b expected %b", out_par, e.par);
                end
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (load_en && ok) begin
            e.data = in_bus[g*8 +: 8];
            e.ch   = 2'(g);
            e.par  = ^e.data;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (load_en && ok) begin
            m_ov = 1'b1;
            if (mode) m_ptr = (g == 3) ? 0 : g + 1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_bus     = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid   = 4'b1111;
        sel        = 2'd2;
        mode       = 1'b0;
        out_ready  = 1'b1;
        in_bus3    = {8'hc3, 8'hb2, 8'ha1};
        in_valid3  = 3'b000;
        sel3       = 2'd0;
        mode3      = 1'b0;
        out_ready3 = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: got out=%0h v=%b ch=%0d rdy=%b expected 0 0 0 0000",
                     out, out_valid, out_ch, in_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out !== 8'h33) begin
            failures++;
            $display("FAIL first_transfer: got v=%b out=%0h expected v=1 out=33", out_valid, out);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0;
        sel  = 2'd2;
        repeat (4) step();
        checks++;
        if (out !== 8'h33 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL fixed_repeat: got out=%0h ch=%0d v=%b expected 33 2 1", out, out_ch, out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [6];
        logic [1:0] exp_ch;
        seq      = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        mode     = 1'b1;
        in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_ch = seq[i];
            checks++;
            if (out_ch !== exp_ch) begin
                failures++;
                $display("FAIL rr_order[%0d]: got ch=%0d expected ch=%0d", i, out_ch, exp_ch);
            end
        end
    endtask

    task automatic test_backpressure();
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'b0000;
        step();
        in_valid = 4'b1111;
        step();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sel = 2'(i);
            step();
            checks++;
            if (out !== 8'h11 || in_ready !== 4'b0000 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got out=%0h rdy=%b v=%b expected 11 0000 1",
                         i, out, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        sel       = 2'd1;
        step();
        checks++;
        if (out !== 8'h22 || out_ch !== 2'd1) begin
            failures++;
            $display("FAIL stall_release: got out=%0h ch=%0d expected 22 1", out, out_ch);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_empty();
        mode     = 1'b1;
        in_valid = 4'b0010;
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_empty: got v=%b expected v=0", out_valid);
        end
        in_valid = 4'b1111;
        step();
        checks++;
        if (out_ch !== 2'd2) begin
            failures++;
            $display("FAIL rr_ptr_hold: got ch=%0d expected ch=2", out_ch);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_out_of_range();
        mode3     = 1'b0;
        sel3      = 2'd2;
        in_valid3 = 3'b111;
        #1;
        checks++;
        if (in_ready3 !== 3'b100) begin
            failures++;
            $display("FAIL oor_ready_in_range: got %b expected 100", in_ready3);
        end
        @(negedge clk);
        checks++;
        if (out_valid3 !== 1'b1 || out3 !== 8'hc3 || out_ch3 !== 2'd2) begin
            failures++;
            $display("FAIL oor_load: got v=%b out=%0h ch=%0d expected 1 c3 2", out_valid3, out3, out_ch3);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (in_ready3 !== 3'b000) begin
            failures++;
            $display("FAIL oor_ready: got %b expected 000", in_ready3);
        end
        @(negedge clk);
        checks++;
        if (out_valid3 !== 1'b0 || out3 !== 8'hc3 || out_ch3 !== 2'd2) begin
            failures++;
            $display("FAIL oor_drop: got v=%b out=%0h ch=%0d expected 0 c3 2", out_valid3, out3, out_ch3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_mid_stall_and_parity();
        mode      = 1'b0;
        sel       = 2'd1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_stall: got v=%b out=%0h ch=%0d rdy=%b expected 0 0 0 0000",
                     out_valid, out, out_ch, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        in_bus   = {8'h44, 8'h33, 8'h03, 8'h07};
        sel      = 2'd0;
        in_valid = 4'b0001;
        step();
        checks++;
        if (out !== 8'h07) begin
            failures++;
            $display("FAIL par_load07: got out=%0h expected 07", out);
        end
`ifdef MUX_NTO1_PARITY_EN
        checks++;
        if (out_par !== 1'b1) begin
            failures++;
            $display("FAIL par_07: got %b expected 1", out_par);
        end
`endif
        out_ready = 1'b1;
        sel       = 2'd1;
        in_valid  = 4'b0010;
        step();
`ifdef MUX_NTO1_PARITY_EN
        checks++;
        if (out_par !== 1'b0) begin
            failures++;
            $display("FAIL par_03: got %b expected 0", out_par);
        end
`endif
        in_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_empty();
        test_out_of_range();
        test_reset_mid_stall_and_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
